serial_adder: RTL and testbench

//  Bit-serial N-bit adder built around a one-bit full-adder cell (two half-adder

---
 rtl/serial_adder.sv | 153 +++++++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands are accepted over a valid/ready
//   handshake, added one bit per clock (LSB first) through a full-adder cell
//   built from two half adders plus an OR, and the result {carry_out, sum} is
//   presented over a second valid/ready handshake.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      a/b/cin hold a valid operand pair
//   in_ready   out  1      block is idle and can accept operands
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in added at bit 0
//   out_valid  out  1      sum/carry_out hold a completed result
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//   carry_out  out  1      carry out of bit WIDTH-1
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q,   a_d;
   logic [WIDTH-1:0] b_q,   b_d;
   logic [WIDTH-1:0] s_q,   s_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q,   c_d;
   logic             cout_q, cout_d;
   logic             ov_q,  ov_d;

   // Full-adder cell: first half adder on the operand bits, second half
   // adder folds in the registered carry, OR merges the two carries.
   logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

   always_comb begin
      ha1_s = a_q[0] ^ b_q[0];
      ha1_c = a_q[0] & b_q[0];
      ha2_s = ha1_s ^ c_q;
      ha2_c = ha1_s & c_q;
      fa_c  = ha1_c | ha2_c;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)      state_d = ADD;
         ADD:     if (cnt_q == LAST) state_d = DONE;
         DONE:    if (out_ready)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Output and datapath next-value logic
   always_comb begin
      in_ready = (state_q == IDLE);
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ov_d     = ov_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d   = a;
               b_d   = b;
               c_d   = cin;
               s_d   = '0;
               cnt_d = '0;
            end
         end
         ADD: begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            c_d = fa_c;
            s_d = {ha2_s, s_q[WIDTH-1:1]};
            if (cnt_q == LAST) begin
               // The final bit is folded in here so the result register
               // loads on the same edge as the last addition.
               sum_d  = s_d;
               cout_d = fa_c;
               ov_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) ov_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         c_q    <= 1'b0;
         cnt_q  <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         s_q    <= s_d;
         c_q    <= c_d;
         cnt_q  <= cnt_d;
         sum_q  <= sum_d;
         cout_q <= cout_d;
         ov_q   <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed bench for serial_adder: a WIDTH=8 instance driven from a vector
//   table plus hand-written stall and reset sequences, and a WIDTH=4 instance
//   swept over every (a, b, cin) combination with random output stalls.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       cin8 = 1'b0, cout8;

   // WIDTH=4 instance
   logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0, sum4;
   logic       cin4 = 1'b0, cout4;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .carry_out(cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .sum(sum4), .carry_out(cout4)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_res4 = 0;

   always @(posedge clk) begin
      if (!rst && out_valid4 && out_ready4) n_res4 <= n_res4 + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One WIDTH=8 transaction. Inputs change on the falling edge; the accept
   // edge is the rising edge that follows in_valid going high.
   task automatic run8(input string nm, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [7:0] es, input logic ec,
                       input int stall, input logic early_rdy);
      int cyc;
      int ir_bad;
      @(negedge clk);
      chk({nm, "_ready_idle"}, in_ready8, 1);
      a8 = va; b8 = vb; cin8 = vc; in_valid8 = 1'b1; out_ready8 = early_rdy;
      @(negedge clk);
      // Operands must have been captured at the accept edge only.
      in_valid8 = 1'b0; a8 = ~va; b8 = vb ^ 8'h5A; cin8 = ~vc;
      cyc = 0; ir_bad = 0;
      while (!out_valid8 && cyc < 40) begin
         if (in_ready8) ir_bad++;
         @(negedge clk);
         cyc++;
      end
      out_ready8 = 1'b0;
      chk({nm, "_latency"}, cyc, 8);
      chk({nm, "_ready_busy"}, ir_bad, 0);
      chk({nm, "_sum"}, sum8, es);
      chk({nm, "_cout"}, cout8, ec);
      for (int s = 0; s < stall; s++) begin
         in_valid8 = s[0];
         a8 = 8'(s * 37 + 1);
         b8 = 8'(s * 11 + 3);
         @(negedge clk);
         chk({nm, "_hold"}, {in_ready8, out_valid8, cout8, sum8}, {1'b0, 1'b1, ec, es});
      end
      in_valid8 = 1'b0;
      chk({nm, "_ready_done"}, in_ready8, 0);
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      chk({nm, "_ov_after"}, out_valid8, 0);
      chk({nm, "_ready_after"}, in_ready8, 1);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vt[7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vt[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vt[4] = '{8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0};
      vt[5] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
      vt[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      // Reset state, with in_valid high to confirm it is ignored under reset.
      rst = 1'b1; in_valid8 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", in_ready8, 1);
      chk("rst_ov", out_valid8, 0);
      chk("rst_sum", sum8, 0);
      chk("rst_cout", cout8, 0);
      rst = 1'b0; in_valid8 = 1'b0;

      for (int i = 0; i < 7; i++)
         run8($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, 0, i[0]);

      // Back-pressure: five stalled cycles with in_valid and operands toggling.
      run8("stall", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 5, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("no_extra_result", out_valid8, 0);
      end

      // Reset in the middle of an addition (bit 3 pending).
      @(negedge clk);
      a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0; in_valid8 = 1'b1;
      @(negedge clk);
      in_valid8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_busy", in_ready8, 0);
      rst = 1'b1; in_valid8 = 1'b1;
      @(negedge clk);
      rst = 1'b0; in_valid8 = 1'b0;
      chk("mid_rst_state", {in_ready8, out_valid8, cout8, sum8}, {1'b1, 1'b0, 1'b0, 8'h00});
      @(negedge clk);
      chk("mid_rst_no_out", out_valid8, 0);
      run8("after_rst", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 0, 1'b0);

      // WIDTH=4 exhaustive sweep with random stalls.
      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         logic [4:0] exp5;
         int cyc;
         v = 9'(i);
         exp5 = {1'b0, v[7:4]} + {1'b0, v[3:0]} + {4'b0, v[8]};
         @(negedge clk);
         a4 = v[7:4]; b4 = v[3:0]; cin4 = v[8]; in_valid4 = 1'b1;
         @(negedge clk);
         in_valid4 = 1'b0; a4 = ~a4; b4 = ~b4;
         cyc = 0;
         while (!out_valid4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         if (cyc != 4) chk($sformatf("w4_latency_%0d", i), cyc, 4);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk($sformatf("w4_%0d", i), {out_valid4, cout4, sum4}, {1'b1, exp5});
         out_ready4 = 1'b1;
         @(negedge clk);
         out_ready4 = 1'b0;
      end
      @(negedge clk);
      chk("w4_result_count", n_res4, 512);
      chk("w4_idle_end", {in_ready4, out_valid4}, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
